// File: rtl/elevator_motion_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : elevator_motion_ctrl                                         |
// | Description : SCAN car motion / door controller for a 7-floor elevator.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module elevator_motion_ctrl #(
  parameter int FLOOR_TICKS = 16,
  parameter int DOOR_TICKS  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] floorButton,
  input  logic [9:1]  internalButton,
  output logic [2:0]  currentFloor,
  output logic [1:0]  currentDirection,
  output logic        doorState,
  output logic        move
);

  localparam int c_MaxTicks = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
  localparam int c_CntW     = $clog2(c_MaxTicks);
  localparam logic [c_CntW-1:0] c_FloorLast = c_CntW'(FLOOR_TICKS - 1);
  localparam logic [c_CntW-1:0] c_DoorLast  = c_CntW'(DOOR_TICKS - 1);
  localparam logic [1:0] c_DirNone = 2'b00;
  localparam logic [1:0] c_DirUp   = 2'b01;
  localparam logic [1:0] c_DirDn   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MOVING    = 2'd1,
    ST_DOOR_OPEN = 2'd2
  } state_t;

  state_t              r_state, w_nextState;
  logic [2:0]          r_floor, w_nextFloor;
  logic [1:0]          r_dir, w_nextDir;
  logic                r_door, w_nextDoor;
  logic                r_move, w_nextMove;
  logic [c_CntW-1:0]   r_tickCnt, w_nextCnt;

  logic [7:1] w_car, w_upCall, w_dnCall, w_anyReq;

  assign w_car = internalButton[7:1];

  for (genvar f = 1; f <= 7; f++) begin : g_callMap
    assign w_upCall[f] = floorButton[2*(f-1)];
    assign w_dnCall[f] = floorButton[2*(f-1)+1];
  end
  assign w_anyReq = w_car | w_upCall | w_dnCall;

  function automatic logic anyAbove(input logic [2:0] f, input logic [7:1] req);
    logic r;
    r = 1'b0;
    for (int i = 1; i <= 7; i++)
      if (i > int'(f)) r = r | req[i];
    return r;
  endfunction

  function automatic logic anyBelow(input logic [2:0] f, input logic [7:1] req);
    logic r;
    r = 1'b0;
    for (int i = 1; i <= 7; i++)
      if (i < int'(f)) r = r | req[i];
    return r;
  endfunction

  function automatic logic [1:0] flipDir(input logic [1:0] d);
    return (d == c_DirUp) ? c_DirDn : c_DirUp;
  endfunction

  // Current-floor view used by IDLE; an unset direction behaves as UP.
  logic [1:0] w_dirEff;
  logic       w_carF, w_upF, w_dnF, w_aheadF, w_behindF;
  assign w_dirEff  = (r_dir == c_DirNone) ? c_DirUp : r_dir;
  assign w_carF    = w_car[r_floor];
  assign w_upF     = w_upCall[r_floor];
  assign w_dnF     = w_dnCall[r_floor];
  assign w_aheadF  = (w_dirEff == c_DirDn) ? anyBelow(r_floor, w_anyReq) : anyAbove(r_floor, w_anyReq);
  assign w_behindF = (w_dirEff == c_DirDn) ? anyAbove(r_floor, w_anyReq) : anyBelow(r_floor, w_anyReq);

  // Floor being reached on the terminal travel tick; clamped at the shaft ends.
  logic [2:0] w_stepFloor;
  logic       w_carG, w_matchG, w_hereG, w_aheadG;
  always_comb begin
    w_stepFloor = r_floor;
    if (r_dir == c_DirUp && r_floor != 3'd7) w_stepFloor = r_floor + 3'd1;
    else if (r_dir == c_DirDn && r_floor != 3'd1) w_stepFloor = r_floor - 3'd1;
  end
  assign w_carG   = w_car[w_stepFloor];
  assign w_matchG = (r_dir == c_DirUp) ? w_upCall[w_stepFloor] : w_dnCall[w_stepFloor];
  assign w_hereG  = w_anyReq[w_stepFloor];
  assign w_aheadG = (r_dir == c_DirDn) ? anyBelow(w_stepFloor, w_anyReq)
                                       : anyAbove(w_stepFloor, w_anyReq);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_floor   <= 3'd1;
      r_dir     <= c_DirNone;
      r_door    <= 1'b0;
      r_move    <= 1'b0;
      r_tickCnt <= '0;
    end else begin
      r_state   <= w_nextState;
      r_floor   <= w_nextFloor;
      r_dir     <= w_nextDir;
      r_door    <= w_nextDoor;
      r_move    <= w_nextMove;
      r_tickCnt <= w_nextCnt;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextFloor = r_floor;
    w_nextDir   = r_dir;
    w_nextDoor  = r_door;
    w_nextMove  = r_move;
    w_nextCnt   = r_tickCnt;
    case (r_state)
      ST_IDLE: begin
        w_nextDoor = 1'b0;
        w_nextMove = 1'b0;
        w_nextCnt  = '0;
        if (w_carF || (r_dir == c_DirUp && w_upF) || (r_dir == c_DirDn && w_dnF) ||
            (r_dir == c_DirNone && (w_upF || w_dnF))) begin
          w_nextState = ST_DOOR_OPEN;
          w_nextDoor  = 1'b1;
          if (r_dir == c_DirNone)
            w_nextDir = w_upF ? c_DirUp : (w_dnF ? c_DirDn : c_DirNone);
        end else if (w_aheadF) begin
          w_nextState = ST_MOVING;
          w_nextMove  = 1'b1;
          w_nextDir   = w_dirEff;
        end else if (w_behindF) begin
          w_nextState = ST_MOVING;
          w_nextMove  = 1'b1;
          w_nextDir   = flipDir(w_dirEff);
        end else if (w_upF || w_dnF) begin
          // Only the opposite-direction hall call remains at this floor.
          w_nextState = ST_DOOR_OPEN;
          w_nextDoor  = 1'b1;
          w_nextDir   = flipDir(r_dir);
        end else if (internalButton[8]) begin
          w_nextState = ST_DOOR_OPEN;
          w_nextDoor  = 1'b1;
        end else begin
          w_nextDir = c_DirNone;
        end
      end
      ST_MOVING: begin
        if (r_tickCnt == c_FloorLast) begin
          w_nextCnt   = '0;
          w_nextFloor = w_stepFloor;
          if (w_carG || w_matchG || !w_aheadG) begin
            w_nextMove = 1'b0;
            if (w_hereG) begin
              w_nextState = ST_DOOR_OPEN;
              w_nextDoor  = 1'b1;
              if (!w_aheadG && !w_carG && !w_matchG)
                w_nextDir = flipDir(r_dir);
            end else begin
              w_nextState = ST_IDLE;
              w_nextDir   = c_DirNone;
            end
          end
        end else begin
          w_nextCnt = r_tickCnt + 1'b1;
        end
      end
      ST_DOOR_OPEN: begin
        w_nextDoor = 1'b1;
        w_nextMove = 1'b0;
        if (internalButton[8]) begin
          w_nextCnt = '0;
        end else if (internalButton[9] || r_tickCnt == c_DoorLast) begin
          w_nextDoor  = 1'b0;
          w_nextState = ST_IDLE;
          w_nextCnt   = '0;
        end else begin
          w_nextCnt = r_tickCnt + 1'b1;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
        w_nextDoor  = 1'b0;
        w_nextMove  = 1'b0;
        w_nextCnt   = '0;
      end
    endcase
  end

  assign currentFloor     = r_floor;
  assign currentDirection = r_dir;
  assign doorState        = r_door;
  assign move             = r_move;

endmodule
`default_nettype wire

// File: tb/tb_elevator_motion_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_elevator_motion_ctrl                                      |
// | Description : Directed self-checking bench for elevator_motion_ctrl.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_elevator_motion_ctrl;

  localparam int F = 16;
  localparam int D = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [13:0] floorButton = '0;
  logic [9:1]  internalButton = '0;
  logic [2:0]  currentFloor;
  logic [1:0]  currentDirection;
  logic        doorState;
  logic        move;

  int nAsserts = 0;
  int nFail    = 0;

  elevator_motion_ctrl #(.FLOOR_TICKS(F), .DOOR_TICKS(D)) dut (
    .clk              (clk),
    .reset            (reset),
    .floorButton      (floorButton),
    .internalButton   (internalButton),
    .currentFloor     (currentFloor),
    .currentDirection (currentDirection),
    .doorState        (doorState),
    .move             (move)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Snapshot of {floor, dir, door, move} for compact checks.
  function automatic logic [31:0] snap();
    return {25'd0, currentFloor, currentDirection, doorState, move};
  endfunction

  function automatic logic [31:0] exp4(input int fl, input int dir, input int dr, input int mv);
    return {25'd0, 3'(fl), 2'(dir), 1'(dr), 1'(mv)};
  endfunction

  initial begin
    // Reset values
    reset = 1'b1;
    step(2);
    check("reset_hold", snap(), exp4(1, 0, 0, 0));
    reset = 1'b0;
    step(1);
    check("reset_idle", snap(), exp4(1, 0, 0, 0));

    // Car call to 5 from floor 1
    internalButton[5] = 1'b1;
    step(1);
    check("t1_depart", snap(), exp4(1, 1, 0, 1));
    step(F - 1);
    check("t1_before_f2", snap(), exp4(1, 1, 0, 1));
    step(1);
    check("t1_at_f2", snap(), exp4(2, 1, 0, 1));
    step(3 * F - 1);
    check("t1_at_f4", snap(), exp4(4, 1, 0, 1));
    step(1);
    check("t1_arrive_f5", snap(), exp4(5, 1, 1, 0));
    internalButton[5] = 1'b0;
    step(D - 1);
    check("t1_door_last", snap(), exp4(5, 1, 1, 0));
    step(1);
    check("t1_door_close", snap(), exp4(5, 1, 0, 0));
    step(1);
    check("t1_idle_dir", snap(), exp4(5, 0, 0, 0));

    // Up to 6 with UP[3] added en route, DN[4] deferred
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    internalButton[6] = 1'b1;
    step(1);
    check("t2_depart", snap(), exp4(1, 1, 0, 1));
    step(F + 2);
    check("t2_at_f2", snap(), exp4(2, 1, 0, 1));
    floorButton[4] = 1'b1;
    floorButton[7] = 1'b1;
    step(F - 2);
    check("t2_stop_f3", snap(), exp4(3, 1, 1, 0));
    floorButton[4] = 1'b0;
    step(D);
    check("t2_close_f3", snap(), exp4(3, 1, 0, 0));
    step(1);
    check("t2_resume_up", snap(), exp4(3, 1, 0, 1));
    step(F);
    check("t2_pass_f4", snap(), exp4(4, 1, 0, 1));
    step(2 * F);
    check("t2_stop_f6", snap(), exp4(6, 1, 1, 0));
    internalButton[6] = 1'b0;
    step(D);
    check("t2_close_f6", snap(), exp4(6, 1, 0, 0));
    step(1);
    check("t2_reverse_dn", snap(), exp4(6, 2, 0, 1));
    step(2 * F);
    check("t2_serve_dn4", snap(), exp4(4, 2, 1, 0));
    floorButton[7] = 1'b0;
    step(D + 1);
    check("t2_idle_f4", snap(), exp4(4, 0, 0, 0));

    // Travel to 7 then a DOWN hall call at 7
    internalButton[7] = 1'b1;
    step(1);
    check("t3_depart", snap(), exp4(4, 1, 0, 1));
    step(3 * F);
    check("t3_arrive_f7", snap(), exp4(7, 1, 1, 0));
    internalButton[7] = 1'b0;
    step(D + 1);
    check("t3_idle_f7", snap(), exp4(7, 0, 0, 0));
    floorButton[13] = 1'b1;
    step(1);
    check("t3_dn7_open", snap(), exp4(7, 2, 1, 0));

    // Door-open hold, open+close together, then close
    floorButton[13] = 1'b0;
    internalButton[8] = 1'b1;
    step(D + 10);
    check("t4_hold_open", snap(), exp4(7, 2, 1, 0));
    internalButton[9] = 1'b1;
    step(3);
    check("t4_open_wins", snap(), exp4(7, 2, 1, 0));
    internalButton[8] = 1'b0;
    step(1);
    check("t4_close_req", snap(), exp4(7, 2, 0, 0));
    internalButton[9] = 1'b0;
    step(1);
    check("t4_idle_dir", snap(), exp4(7, 0, 0, 0));
    internalButton[8] = 1'b1;
    step(1);
    check("t4_idle_open_req", snap(), exp4(7, 0, 1, 0));
    internalButton[8] = 1'b0;
    internalButton[9] = 1'b1;
    step(1);
    check("t4_idle_close", snap(), exp4(7, 0, 0, 0));
    internalButton[9] = 1'b0;

    // At floor 4 heading UP with calls above and below
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    internalButton[4] = 1'b1;
    step(1);
    step(3 * F);
    check("t5_arrive_f4", snap(), exp4(4, 1, 1, 0));
    internalButton[4] = 1'b0;
    internalButton[6] = 1'b1;
    internalButton[2] = 1'b1;
    step(D);
    check("t5_close_f4", snap(), exp4(4, 1, 0, 0));
    step(1);
    check("t5_go_up_first", snap(), exp4(4, 1, 0, 1));
    step(2 * F);
    check("t5_stop_f6", snap(), exp4(6, 1, 1, 0));
    internalButton[6] = 1'b0;
    step(D + 1);
    check("t5_reverse_dn", snap(), exp4(6, 2, 0, 1));
    step(3 * F);
    check("t5_pass_f3", snap(), exp4(3, 2, 0, 1));

    // Asynchronous reset mid-travel
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_reset", snap(), exp4(1, 0, 0, 0));
    internalButton[2] = 1'b0;
    step(1);
    reset = 1'b0;
    step(2);
    check("t6_post_reset", snap(), exp4(1, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
`default_nettype wire
